// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single regfile write port between the pipeline
// writeback stage and a long-latency unit. Unit results are buffered in a
// small FIFO and drained into idle write slots. A one-cycle pipeline stall is
// forced when the FIFO is full or its head has waited too long. A busy mask of
// registers with buffered writes is exported for the hazard logic.
module rf_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int AW           = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_we,
    input  logic [4:0]    wb_num,
    input  logic [31:0]   wb_data,
    input  logic          mu_valid,
    output logic          mu_ready,
    input  logic [4:0]    mu_num,
    input  logic [31:0]   mu_data,
    output logic          rf_we,
    output logic [4:0]    rf_num,
    output logic [31:0]   rf_data,
    output logic          stall_req,
    output logic [31:0]   busy_mask,
    output logic [AW:0]   fifo_count
);

    localparam int            SW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    // FIFO control state
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [SW-1:0] r_starve;

    // FIFO storage (contents are don't-care until marked valid by the count)
    logic [4:0]    r_num  [DEPTH];
    logic [31:0]   r_data [DEPTH];

    logic          w_full;
    logic          w_nonempty;
    logic          w_starved;
    logic          w_stall;
    logic          w_wb_ok;
    logic          w_deq;
    logic          w_enq;
    logic          w_mu_ready;
    logic [31:0]   w_busy;

    // Stall and readiness depend only on registered state; reset forces them low.
    assign w_full     = (r_count == DEPTH_C);
    assign w_nonempty = (r_count != {(AW + 1){1'b0}});
    assign w_starved  = (r_starve >= LIMIT_C);
    assign w_stall    = !reset && (w_full || (w_nonempty && w_starved));
    assign w_mu_ready = !reset && (r_count < DEPTH_C);

    // A WB write to r0 is an idle slot the FIFO may use.
    assign w_wb_ok = wb_we && (wb_num != 5'd0);

    // Drain the head on a forced stall, or whenever the WB slot is idle.
    assign w_deq = !reset && w_nonempty && (w_stall || !w_wb_ok);

    // Results for r0 complete the handshake but are dropped.
    assign w_enq = w_mu_ready && mu_valid && (mu_num != 5'd0);

    assign mu_ready   = w_mu_ready;
    assign stall_req  = w_stall;
    assign fifo_count = reset ? {(AW + 1){1'b0}} : r_count;
    assign busy_mask  = reset ? 32'd0 : w_busy;

    // Write-port mux: FIFO drain beats WB only when forced or when WB is idle.
    always_comb begin
        rf_we   = 1'b0;
        rf_num  = 5'd0;
        rf_data = 32'd0;
        if (w_deq) begin
            rf_we   = 1'b1;
            rf_num  = r_num[r_rd_ptr];
            rf_data = r_data[r_rd_ptr];
        end else if (!reset && w_wb_ok) begin
            rf_we   = 1'b1;
            rf_num  = wb_num;
            rf_data = wb_data;
        end else begin
            rf_we   = 1'b0;
        end
    end

    // Busy mask: OR of one-hot destinations over the occupied FIFO slots.
    always_comb begin
        logic [AW-1:0] v_off;
        w_busy = 32'd0;
        v_off  = {AW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            v_off = AW'(i) - r_rd_ptr;
            if ({1'b0, v_off} < r_count) begin
                w_busy[r_num[AW'(i)]] = 1'b1;
            end else begin
                w_busy = w_busy;
            end
        end
    end

    // Pointer, occupancy and head-starvation bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= {(AW + 1){1'b0}};
            r_starve <= {SW{1'b0}};
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (!w_nonempty || w_deq) begin
                r_starve <= {SW{1'b0}};
            end else if (r_starve < LIMIT_C) begin
                r_starve <= r_starve + SW'(1);
            end else begin
                r_starve <= r_starve;
            end
        end
    end

    // Capture accepted unit results into the tail slot.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_num[r_wr_ptr]  <= mu_num;
            r_data[r_wr_ptr] <= mu_data;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a queue-based model.
module tb_rf_write_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_num;
    logic [31:0] wb_data;
    logic        mu_valid;
    logic        mu_ready;
    logic [4:0]  mu_num;
    logic [31:0] mu_data;
    logic        rf_we;
    logic [4:0]  rf_num;
    logic [31:0] rf_data;
    logic        stall_req;
    logic [31:0] busy_mask;
    logic [2:0]  fifo_count;

    rf_write_arbiter #(.DEPTH(DEPTH), .AW(2), .STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_we      (wb_we),
        .wb_num     (wb_num),
        .wb_data    (wb_data),
        .mu_valid   (mu_valid),
        .mu_ready   (mu_ready),
        .mu_num     (mu_num),
        .mu_data    (mu_data),
        .rf_we      (rf_we),
        .rf_num     (rf_num),
        .rf_data    (rf_data),
        .stall_req  (stall_req),
        .busy_mask  (busy_mask),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending unit results as a queue plus a wait counter.
    logic [4:0]  q_num  [$];
    logic [31:0] q_data [$];
    int          m_starve = 0;
    int          m_size;
    bit          m_drain;
    bit          m_enq;

    typedef struct {
        logic        rst;
        logic        wb_we;
        logic [4:0]  wb_num;
        logic [31:0] wb_data;
        logic        mu_valid;
        logic [4:0]  mu_num;
        logic [31:0] mu_data;
        logic        e_we;
        logic [4:0]  e_num;
        logic [31:0] e_data;
        logic        e_stall;
        logic        e_ready;
        logic [31:0] e_busy;
        logic [2:0]  e_count;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive_idle();
        wb_we    = 1'b0;
        wb_num   = 5'd0;
        wb_data  = 32'd0;
        mu_valid = 1'b0;
        mu_num   = 5'd0;
        mu_data  = 32'd0;
    endtask

    // Evaluate the model for the current cycle and compare every output.
    task automatic sample();
        bit          wb_ok;
        logic        e_we;
        logic [4:0]  e_num;
        logic [31:0] e_data;
        logic        e_stall;
        logic        e_ready;
        logic [31:0] e_busy;
        logic [2:0]  e_count;
        @(negedge clk);
        m_size  = q_num.size();
        e_we    = 1'b0;
        e_num   = 5'd0;
        e_data  = 32'd0;
        e_stall = 1'b0;
        e_ready = 1'b0;
        e_busy  = 32'd0;
        e_count = 3'd0;
        m_drain = 1'b0;
        m_enq   = 1'b0;
        if (!reset) begin
            e_count = 3'(m_size);
            e_ready = (m_size < DEPTH);
            e_stall = (m_size == DEPTH) || (m_size > 0 && m_starve >= LIMIT);
            wb_ok   = wb_we && (wb_num != 5'd0);
            if (m_size > 0 && (e_stall || !wb_ok)) begin
                m_drain = 1'b1;
                e_we    = 1'b1;
                e_num   = q_num[0];
                e_data  = q_data[0];
            end else if (wb_ok) begin
                e_we    = 1'b1;
                e_num   = wb_num;
                e_data  = wb_data;
            end
            foreach (q_num[k]) e_busy[q_num[k]] = 1'b1;
            m_enq = e_ready && mu_valid && (mu_num != 5'd0);
        end
        chk("model_rf_we",      32'(rf_we),      32'(e_we));
        chk("model_rf_num",     32'(rf_num),     32'(e_num));
        chk("model_rf_data",    rf_data,         e_data);
        chk("model_stall",      32'(stall_req),  32'(e_stall));
        chk("model_mu_ready",   32'(mu_ready),   32'(e_ready));
        chk("model_busy",       busy_mask,       e_busy);
        chk("model_fifo_count", 32'(fifo_count), 32'(e_count));
    endtask

    // Clock edge: advance the model with the decisions taken this cycle.
    task automatic advance();
        @(posedge clk);
        if (reset) begin
            q_num.delete();
            q_data.delete();
            m_starve = 0;
        end else begin
            if (m_drain) begin
                void'(q_num.pop_front());
                void'(q_data.pop_front());
            end
            if (m_enq) begin
                q_num.push_back(mu_num);
                q_data.push_back(mu_data);
            end
            if (m_size == 0 || m_drain) m_starve = 0;
            else if (m_starve < LIMIT)  m_starve = m_starve + 1;
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();

        // rst, wb_we, wb_num, wb_data, mu_valid, mu_num, mu_data |
        // e_we, e_num, e_data, e_stall, e_ready, e_busy, e_count
        tbl[0]  = '{1'b1, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 32'h0,  3'd0};
        tbl[1]  = '{1'b1, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 32'h0,  3'd0};
        tbl[2]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 32'h0,  3'd0};
        tbl[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 32'h0,  3'd0};
        tbl[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'h1234, 1'b0, 1'b1, 32'h20, 3'd1};
        tbl[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 32'h0,  3'd0};
        tbl[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'h55,   1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 32'h0,  3'd0};
        tbl[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 32'h0,  3'd0};
        tbl[8]  = '{1'b0, 1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd7, 32'h777,  1'b1, 5'd3, 32'hAAAA, 1'b0, 1'b1, 32'h0,  3'd0};
        tbl[9]  = '{1'b0, 1'b1, 5'd0, 32'hBBBB, 1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'h777,  1'b0, 1'b1, 32'h80, 3'd1};
        tbl[10] = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 32'h0,  3'd0};

        // Directed table: reset, single push/drain, r0 handshakes, wb r0 slot.
        for (int i = 0; i < 11; i++) begin
            reset    = tbl[i].rst;
            wb_we    = tbl[i].wb_we;
            wb_num   = tbl[i].wb_num;
            wb_data  = tbl[i].wb_data;
            mu_valid = tbl[i].mu_valid;
            mu_num   = tbl[i].mu_num;
            mu_data  = tbl[i].mu_data;
            sample();
            chk($sformatf("tbl_rf_we[%0d]", i),    32'(rf_we),      32'(tbl[i].e_we));
            chk($sformatf("tbl_rf_num[%0d]", i),   32'(rf_num),     32'(tbl[i].e_num));
            chk($sformatf("tbl_rf_data[%0d]", i),  rf_data,         tbl[i].e_data);
            chk($sformatf("tbl_stall[%0d]", i),    32'(stall_req),  32'(tbl[i].e_stall));
            chk($sformatf("tbl_mu_ready[%0d]", i), 32'(mu_ready),   32'(tbl[i].e_ready));
            chk($sformatf("tbl_busy[%0d]", i),     busy_mask,       tbl[i].e_busy);
            chk($sformatf("tbl_count[%0d]", i),    32'(fifo_count), 32'(tbl[i].e_count));
            advance();
        end

        // FIFO fills behind continuous WB writes, then a forced drain.
        drive_idle();
        wb_we   = 1'b1;
        wb_num  = 5'd1;
        wb_data = 32'h1111_0001;
        for (int i = 0; i < 4; i++) begin
            mu_valid = 1'b1;
            mu_num   = 5'(8 + i);
            mu_data  = 32'h8000_0000 + 32'(i);
            sample();
            chk("t3_accept", 32'(mu_ready), 32'd1);
            advance();
        end
        mu_valid = 1'b0;
        sample();
        chk("t3_full_count", 32'(fifo_count), 32'd4);
        chk("t3_full_ready", 32'(mu_ready),   32'd0);
        chk("t3_full_stall", 32'(stall_req),  32'd1);
        chk("t3_drain_num",  32'(rf_num),     32'd8);
        chk("t3_drain_data", rf_data,         32'h8000_0000);
        advance();
        sample();
        chk("t3_after_count", 32'(fifo_count), 32'd3);
        chk("t3_after_stall", 32'(stall_req),  32'd0);
        chk("t3_wb_resume",   32'(rf_num),     32'd1);
        advance();
        drive_idle();
        repeat (3) begin
            sample();
            advance();
        end
        sample();
        chk("t3_empty", 32'(fifo_count), 32'd0);
        advance();

        // Single entry starved by continuous WB writes.
        wb_we    = 1'b1;
        wb_num   = 5'd2;
        wb_data  = 32'h2222_2222;
        mu_valid = 1'b1;
        mu_num   = 5'd9;
        mu_data  = 32'hDEAD_BEEF;
        sample();
        advance();
        mu_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sample();
            chk("t4_no_stall", 32'(stall_req), 32'd0);
            chk("t4_wb_wins",  32'(rf_num),    32'd2);
            advance();
        end
        sample();
        chk("t4_stall",      32'(stall_req), 32'd1);
        chk("t4_drain_num",  32'(rf_num),    32'd9);
        chk("t4_drain_data", rf_data,        32'hDEAD_BEEF);
        advance();
        sample();
        chk("t4_count", 32'(fifo_count), 32'd0);
        chk("t4_stall_clear", 32'(stall_req), 32'd0);
        chk("t4_wb_back", 32'(rf_num), 32'd2);
        advance();

        // Pending duplicates discarded by reset.
        wb_we   = 1'b1;
        wb_num  = 5'd1;
        wb_data = 32'h1;
        for (int i = 0; i < 3; i++) begin
            mu_valid = 1'b1;
            mu_num   = (i == 2) ? 5'd4 : 5'd3;
            mu_data  = 32'h30 + 32'(i);
            sample();
            advance();
        end
        mu_valid = 1'b0;
        sample();
        chk("t6_busy",  busy_mask,       32'h18);
        chk("t6_count", 32'(fifo_count), 32'd3);
        advance();
        reset = 1'b1;
        drive_idle();
        repeat (2) begin
            sample();
            chk("t6_rst_count", 32'(fifo_count), 32'd0);
            chk("t6_rst_busy",  busy_mask,       32'd0);
            chk("t6_rst_we",    32'(rf_we),      32'd0);
            advance();
        end
        reset = 1'b0;
        repeat (4) begin
            sample();
            chk("t6_no_write", 32'(rf_we), 32'd0);
            advance();
        end

        // Randomized traffic; the second half keeps WB busy to provoke starvation.
        for (int n = 0; n < 800; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            wb_we    = (n < 400) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) != 0);
            wb_num   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb_data  = $urandom;
            mu_valid = ($urandom_range(0, 2) != 0);
            mu_num   = 5'($urandom_range(0, 7));
            mu_data  = $urandom;
            sample();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the single regfile write port (rdNum/rdData/rdWriteEnable) between the pipeline writeback stage and a long-latency unit (multiply/divide or similar) that completes out of band. Pipeline writes have priority. Unit results are buffered in a small FIFO and drained into idle write slots. When the FIFO is full, or the head entry has waited too long, the block forces a one-cycle pipeline stall to drain it. It also exports a busy mask of registers with pending buffered writes, which the hazard logic uses.

Parameters:
DEPTH, 4, FIFO entries for unit results; power of two, at least 2.
AW, 2, log2(DEPTH).
STARVE_LIMIT, 8, consecutive non-drained cycles with FIFO non-empty before a forced drain.

Ports:
clk  input  1  clock, posedge.
reset  input  1  synchronous, active-high.
wb_we  input  1  pipeline WB write request.
wb_num  input  5  pipeline WB destination register.
wb_data  input  32  pipeline WB data.
mu_valid  input  1  unit result valid.
mu_ready  output  1  arbiter can accept a unit result.
mu_num  input  5  unit destination register.
mu_data  input  32  unit result data.
rf_we  output  1  to regfile rdWriteEnable.
rf_num  output  5  to regfile rdNum.
rf_data  output  32  to regfile rdData.
stall_req  output  1  freezes the pipeline for this cycle.
busy_mask  output  32  bit n=1: register n has a pending write in the FIFO.
fifo_count  output  AW+1  current FIFO occupancy.

Behaviour:
- Reset (sync) clears FIFO pointers, count, and the starvation counter. Pending entries are discarded.
- While reset=1: mu_ready=0, rf_we=0, stall_req=0, busy_mask=0, fifo_count=0. rf_num and rf_data are 0 whenever rf_we=0.
- Enqueue occurs on a cycle where mu_valid and mu_ready are both 1.
  - mu_ready = (fifo_count < DEPTH). It depends on registered count only, so there is no full-FIFO pass-through even if a dequeue happens in the same cycle.
  - A unit result with mu_num=0 completes the handshake but is not enqueued.
- No bypass path: an accepted result reaches rf_we no earlier than 1 cycle after acceptance.
- stall_req is a Moore output (registered state only): 1 iff fifo_count==DEPTH, or (fifo_count>0 and starve_cnt>=STARVE_LIMIT).
- Write-port selection each cycle, in priority order:
  1. stall_req=1: drain the FIFO head. wb_* is ignored that cycle; the pipeline re-presents the same WB next cycle.
  2. wb_we=1 and wb_num!=0: write wb_num/wb_data.
  3. FIFO non-empty: drain the head.
  4. Otherwise: rf_we=0.
- wb_we with wb_num=0 is treated as idle, so the FIFO may drain in that slot.
- Simultaneous enqueue and dequeue: count unchanged, pointers both advance, each wrapping modulo DEPTH.
- starve_cnt:
  - 0 when the FIFO is empty or the head drained this cycle.
  - Otherwise increments, saturating at STARVE_LIMIT.
- busy_mask is the OR of one-hot(num) over valid entries.
  - An entry being drained this cycle still shows in busy_mask; its bit clears next cycle unless a duplicate entry remains.
  - Duplicate destinations are allowed and drain in FIFO order.
- The arbiter never reorders writes. Issue logic must stall any instruction that reads or writes a register whose busy_mask bit is set, which rules out RAW and WAW hazards through the FIFO.
- stall_req has no combinational path from any input.

Test Plan:
1. Assert reset 2 cycles, then release → all outputs 0 during reset; after release mu_ready=1, fifo_count=0, stall_req=0.
2. wb idle; unit pushes r5=0x00001234 → cycle+1: busy_mask=0x00000020, fifo_count=1; rf_we=1, rf_num=5, rf_data=0x00001234. Cycle+2: busy_mask=0, fifo_count=0.
3. wb writes r1 every cycle; unit pushes r8..r11 back-to-back → fifo_count reaches 4, mu_ready=0, stall_req=1 for one cycle, r8 written, wb ignored; count=3, next cycle wb r1 resumes.
4. One entry r9=0xDEADBEEF; wb writes r2 continuously → starve_cnt reaches 8 after 8 cycles, stall_req=1, r9 written, starve_cnt=0, fifo_count=0.
5. Unit pushes mu_num=0 → handshake accepted, fifo_count stays 0, no rf_we; wb_we=1 with wb_num=0 and a pending entry → FIFO drains that cycle.
6. Three entries pending (r3,r3,r4); assert reset → fifo_count=0, busy_mask=0; no r3/r4 writes occur after reset release.
